// File: rtl/crack_dispatcher.sv
// Key-range work distributor for a four-cracker array: chunks the range, loads idle crackers, stops all on a hit.
// Optional DISPATCH_STATS_EN builds a saturating count of issued chunks; otherwise chunks_issued is tied to 0.
module crack_dispatcher #(
  parameter int unsigned KEY_W      = 32,
  parameter int unsigned CHUNK_LOG2 = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_base,
  input  logic [KEY_W-1:0] key_limit,
  input  logic [3:0]       cracker_ready,
  input  logic             success,
  input  logic [1:0]       successful_cracker,
  output logic [3:0]       cracker_load,
  output logic [KEY_W-1:0] chunk_first,
  output logic [KEY_W-1:0] chunk_last,
  output logic             cracker_stop,
  output logic             busy,
  output logic             found,
  output logic [1:0]       found_cracker,
  output logic             exhausted,
  output logic [KEY_W-1:0] chunks_issued
);

  localparam int unsigned EXT_W = KEY_W + 1;
  localparam logic [EXT_W-1:0] CHUNK_SPAN = {{(EXT_W-CHUNK_LOG2){1'b0}}, {CHUNK_LOG2{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t           state, state_nx;
  logic [KEY_W-1:0] next_key, next_key_nx;
  logic [KEY_W-1:0] limit, limit_nx;
  logic [3:0]       load_nx;
  logic [KEY_W-1:0] first_nx, last_nx;
  logic             stop_nx;
  logic [1:0]       found_cracker_nx;
  logic             launch;
  logic [3:0]       eligible, pick;
  logic [EXT_W-1:0] end_ext;
  logic [KEY_W-1:0] chunk_end;

  // A cracker strobed last cycle may still show ready, so it is masked out.
  assign eligible = cracker_ready & ~cracker_load;
  assign pick     = eligible & (~eligible + 4'd1);

  // Chunk end computed one bit wider so a chunk near all-ones clamps instead of wrapping.
  assign end_ext   = {1'b0, next_key} + CHUNK_SPAN;
  assign chunk_end = (end_ext > {1'b0, limit}) ? limit : end_ext[KEY_W-1:0];

  assign launch = start && (state == S_IDLE || state == S_FOUND || state == S_EXHAUSTED)
                  && (key_base <= key_limit);

  always_comb begin
    state_nx         = state;
    next_key_nx      = next_key;
    limit_nx         = limit;
    load_nx          = '0;
    first_nx         = chunk_first;
    last_nx          = chunk_last;
    stop_nx          = 1'b0;
    found_cracker_nx = found_cracker;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (launch) begin
          next_key_nx      = key_base;
          limit_nx         = key_limit;
          found_cracker_nx = '0;
          state_nx         = S_DISPATCH;
        end else if (start) begin
          state_nx = S_EXHAUSTED;
        end
      end
      S_DISPATCH: begin
        if (success) begin
          stop_nx          = 1'b1;
          found_cracker_nx = successful_cracker;
          state_nx         = S_FOUND;
        end else if (|eligible) begin
          load_nx  = pick;
          first_nx = next_key;
          last_nx  = chunk_end;
          if (chunk_end == limit) state_nx = S_DRAIN;
          else                    next_key_nx = chunk_end + KEY_W'(1);
        end
      end
      S_DRAIN: begin
        if (success) begin
          stop_nx          = 1'b1;
          found_cracker_nx = successful_cracker;
          state_nx         = S_FOUND;
        end else if (cracker_ready == 4'b1111) begin
          state_nx = S_EXHAUSTED;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      next_key      <= '0;
      limit         <= '0;
      cracker_load  <= '0;
      chunk_first   <= '0;
      chunk_last    <= '0;
      cracker_stop  <= 1'b0;
      busy          <= 1'b0;
      found         <= 1'b0;
      found_cracker <= '0;
      exhausted     <= 1'b0;
    end else begin
      state         <= state_nx;
      next_key      <= next_key_nx;
      limit         <= limit_nx;
      cracker_load  <= load_nx;
      chunk_first   <= first_nx;
      chunk_last    <= last_nx;
      cracker_stop  <= stop_nx;
      busy          <= (state_nx == S_DISPATCH) || (state_nx == S_DRAIN);
      found         <= (state_nx == S_FOUND);
      found_cracker <= found_cracker_nx;
      exhausted     <= (state_nx == S_EXHAUSTED);
    end
  end

`ifdef DISPATCH_STATS_EN
  // Saturating chunk counter, cleared on each accepted search.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         chunks_issued <= '0;
    else if (launch)                      chunks_issued <= '0;
    else if (|load_nx && !(&chunks_issued)) chunks_issued <= chunks_issued + KEY_W'(1);
  end
`else
  assign chunks_issued = '0;
`endif

endmodule
